// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial two's-complement subtractor. Computes a - b one
//                bit per clock, LSB first, through a single full-adder cell
//                fed with ~b and an initial carry of 1.
//  Ports       : clk        - clock, rising-edge active
//                reset      - asynchronous active-high reset
//                start      - request, accepted when idle or in the done cycle
//                a, b       - minuend / subtrahend, sampled on accept
//                busy       - high while bits are being processed
//                done       - one-cycle pulse, results updated
//                difference - a - b modulo 2^WIDTH
//                borrowout  - unsigned a < b
//                overflow   - signed overflow of the subtraction
//                zero       - difference == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrowout,
    output logic             overflow,
    output logic             zero
);

    localparam int              CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_count;
    logic               r_carry;

    logic               w_accept;
    logic               w_last;
    logic               w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_result;

    // A new operation may start from IDLE or directly out of the DONE cycle.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_count == C_LAST);

    // Single full-adder cell; opb already holds ~b.
    assign w_sum    = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_cout   = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
    assign w_result = {w_sum, r_result[WIDTH-1:1]};

    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = start ? ST_SHIFT : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_carry    <= 1'b0;
            difference <= '0;
            borrowout  <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (w_accept) begin
            r_opa    <= a;
            r_opb    <= ~b;
            r_result <= '0;
            r_count  <= '0;
            r_carry  <= 1'b1;
        end else if (r_state == ST_SHIFT) begin
            r_opa    <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb    <= {1'b0, r_opb[WIDTH-1:1]};
            r_result <= w_result;
            r_carry  <= w_cout;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                // r_carry here is the carry into the MSB, w_cout the carry out.
                difference <= w_result;
                borrowout  <= ~w_cout;
                overflow   <= r_carry ^ w_cout;
                zero       <= (w_result == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (WIDTH = 8) using
//                a scoreboard queue of reference results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] difference;
    logic         borrowout;
    logic         overflow;
    logic         zero;

    int   checks;
    int   errors;
    exp_t sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrowout  (borrowout),
        .overflow   (overflow),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.bo = (x < y);
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
        e.z  = (e.d == '0);
        return e;
    endfunction

    // Drive a start pulse at a negedge and record the reference result.
    // Returns at the negedge just after the accepting edge, start low.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        sb.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Inline compare of the held result against the scoreboard head.
    task automatic test_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (difference !== e.d) begin
            errors++;
            $display("FAIL %s difference: got %h expected %h", name, difference, e.d);
        end
        checks++;
        if (borrowout !== e.bo) begin
            errors++;
            $display("FAIL %s borrowout: got %b expected %b", name, borrowout, e.bo);
        end
        checks++;
        if (overflow !== e.ov) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow, e.ov);
        end
        checks++;
        if (zero !== e.z) begin
            errors++;
            $display("FAIL %s zero: got %b expected %b", name, zero, e.z);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, difference, borrowout, overflow, zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bo=%b ov=%b z=%b expected all 0",
                     busy, done, difference, borrowout, overflow, zero);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] va [5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h2A};
        logic [W-1:0] vb [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h2A};
        int cyc;
        int busy_cnt;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            busy_cnt = 0;
            cyc      = 0;
            while (!done && cyc < 40) begin
                if (busy) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc !== W) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d cycles expected %0d", i, cyc, W);
            end
            checks++;
            if (busy_cnt !== W) begin
                errors++;
                $display("FAIL basic_busy[%0d]: got %0d busy cycles expected %0d", i, busy_cnt, W);
            end
            test_result($sformatf("basic[%0d]", i));
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || difference !== va[i] - vb[i]) begin
                errors++;
                $display("FAIL basic_hold[%0d]: got done=%b diff=%h expected done=0 diff=%h",
                         i, done, difference, va[i] - vb[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] bnd [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        logic [W-1:0] pa [$];
        logic [W-1:0] pb [$];
        int cyc;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                pa.push_back(bnd[i]);
                pb.push_back(bnd[j]);
            end
        for (int k = 0; k < 200; k++) begin
            pa.push_back(W'($urandom_range(0, 255)));
            pb.push_back(W'($urandom_range(0, 255)));
        end
        start_op(pa.pop_front(), pb.pop_front());
        wait_done(cyc);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL sweep_first_latency: got %0d expected %0d", cyc, W);
        end
        forever begin
            if (!done) begin
                errors++; checks++;
                $display("FAIL sweep_timeout: done not seen");
                return;
            end
            test_result("sweep");
            if (pa.size() == 0) break;
            // Back-to-back: start held high in the DONE cycle.
            start = 1'b1;
            a     = pa.pop_front();
            b     = pb.pop_front();
            sb.push_back(model(a, b));
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) start = 1'b0;
            end while (!done && cyc < 40);
            checks++;
            if (cyc !== W + 1) begin
                errors++;
                $display("FAIL sweep_spacing: got %0d cycles expected %0d", cyc, W + 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(8'h40, 8'h11);
        repeat (3) @(negedge clk);
        // Restart attempt mid-operation must be ignored.
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc !== W - 4) begin
            errors++;
            $display("FAIL ignore_start_latency: got %0d expected %0d", cyc, W - 4);
        end
        test_result("ignore_start");
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        sb.push_back(model(8'h10, 8'h01));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || difference !== 8'h2F) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b diff=%h expected busy=1 diff=2f", busy, difference);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected %0d", cyc + 1, W + 1);
        end
        test_result("b2b");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(8'h33, 8'h11);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, difference, borrowout, overflow, zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h bo=%b ov=%b z=%b expected all 0",
                     busy, done, difference, borrowout, overflow, zero);
        end
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        start_op(8'h09, 8'h04);
        wait_done(cyc);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL after_reset_latency: got %0d expected %0d", cyc, W);
        end
        test_result("after_reset");
        checks++;
        if (difference !== 8'h05) begin
            errors++;
            $display("FAIL after_reset_value: got %h expected 05", difference);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        test_reset();
        test_basic();
        test_sweep();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
